// File: rtl/ps_defragmenter_unpacker_mc_if.sv
// ============================================================================
// Module   : ps_defragmenter_unpacker_mc_if
// Brief    : Input fragment stream and output packet stream bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface ps_defragmenter_unpacker_mc_if #(
  parameter int WIDTH    = 16,
  parameter int CH_WIDTH = 2
);
  logic [WIDTH-1:0]    i_dat;
  logic                i_val;
  logic                i_rdy;
  logic [WIDTH-1:0]    o_dat;
  logic [CH_WIDTH-1:0] o_chn;
  logic                o_val;
  logic                o_sop;
  logic                o_eop;
  logic                o_rdy;
  logic                o_err;

  modport slave (
    input  i_dat, i_val, o_rdy,
    output i_rdy, o_dat, o_chn, o_val, o_sop, o_eop, o_err
  );

  modport master (
    output i_dat, i_val, o_rdy,
    input  i_rdy, o_dat, o_chn, o_val, o_sop, o_eop, o_err
  );
endinterface

`default_nettype wire

// File: rtl/ps_defragmenter_unpacker_mc.sv
// ============================================================================
// Module   : ps_defragmenter_unpacker_mc
// Brief    : Strips headers/padding from aligned multi-channel fragments and
//            emits payload with per-channel sop/eop through a 2-entry skid.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps_defragmenter_unpacker_mc #(
  parameter int WIDTH     = 16,
  parameter int ALIGN     = 2,
  parameter int LEN_WIDTH = 8,
  parameter int CHANNELS  = 4
) (
  input  wire logic clk,
  input  wire logic reset,
  ps_defragmenter_unpacker_mc_if.slave bus
);

  localparam int c_ch_width = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int c_aw       = (ALIGN > 1) ? $clog2(ALIGN) : 1;
  localparam int c_ew       = WIDTH + c_ch_width + 2;
  localparam logic [c_ch_width:0] c_chn_lim = (c_ch_width + 1)'(CHANNELS);

  if ((1 + c_ch_width + LEN_WIDTH > WIDTH) || (ALIGN < 1) || (CHANNELS < 1)) begin : g_bad_cfg
    $error("ps_defragmenter_unpacker_mc: invalid parameter combination");
  end

  typedef enum logic [1:0] {
    ST_HEAD  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DROP  = 2'd2,
    ST_ALIGN = 2'd3
  } state_t;

  state_t                r_state;
  logic [LEN_WIDTH-1:0]  r_lcnt;
  logic                  r_fin;
  logic [c_ch_width-1:0] r_chn;
  logic                  r_err;
  logic [CHANNELS-1:0]   r_sop_pend;
  logic [1:0]            r_cnt;
  logic [c_ew-1:0]       r_b0;
  logic [c_ew-1:0]       r_b1;
  logic                  r_rdy;

  logic                  w_in_xfer;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_last;
  logic                  w_eop;
  logic                  w_hdr_bad;
  logic [c_ch_width-1:0] w_hdr_chn;
  logic [c_aw-1:0]       w_acnt;
  logic                  w_has_pad;
  logic                  w_pad_last;
  logic [c_ew-1:0]       w_entry;
  logic [1:0]            w_cnt_nxt;

  assign w_in_xfer  = bus.i_val & r_rdy;
  assign w_pop      = (r_cnt != 2'd0) & bus.o_rdy;
  assign w_push     = w_in_xfer & (r_state == ST_PASS);
  assign w_last     = (r_lcnt == '0);
  assign w_eop      = r_fin & w_last;
  assign w_hdr_chn  = (CHANNELS == 1) ? '0 : bus.i_dat[LEN_WIDTH+c_ch_width-1:LEN_WIDTH];
  assign w_hdr_bad  = ({1'b0, w_hdr_chn} >= c_chn_lim);
  assign w_has_pad  = (w_acnt != '0);
  assign w_pad_last = (w_acnt == c_aw'(1));
  assign w_entry    = {bus.i_dat, r_chn, r_sop_pend[r_chn], w_eop};

  // Align counter holds the pad count of the current fragment, loaded at the header.
  if (ALIGN > 1) begin : g_acnt
    logic [c_aw-1:0] r_acnt;
    always_ff @(posedge clk) begin
      if (reset) begin
        r_acnt <= '0;
      end else if (w_in_xfer) begin
        if (r_state == ST_HEAD) begin
          r_acnt <= c_aw'((ALIGN - ((32'(bus.i_dat[LEN_WIDTH-1:0]) + 32'd2) % ALIGN)) % ALIGN);
        end else if (r_state == ST_ALIGN) begin
          r_acnt <= r_acnt - 1'b1;
        end
      end
    end
    assign w_acnt = r_acnt;
  end else begin : g_no_acnt
    assign w_acnt = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_HEAD;
      r_lcnt     <= '0;
      r_fin      <= 1'b0;
      r_chn      <= '0;
      r_err      <= 1'b0;
      r_sop_pend <= '1;
    end else begin
      r_err <= 1'b0;
      if (w_in_xfer) begin
        case (r_state)
          ST_HEAD: begin
            r_lcnt <= bus.i_dat[LEN_WIDTH-1:0];
            r_fin  <= bus.i_dat[WIDTH-1];
            r_chn  <= w_hdr_chn;
            if (w_hdr_bad) begin
              r_state <= ST_DROP;
              r_err   <= 1'b1;
            end else begin
              r_state <= ST_PASS;
            end
          end
          ST_PASS, ST_DROP: begin
            if (r_state == ST_PASS) begin
              r_sop_pend[r_chn] <= w_eop;
            end
            if (w_last) begin
              r_state <= w_has_pad ? ST_ALIGN : ST_HEAD;
            end else begin
              r_lcnt <= r_lcnt - 1'b1;
            end
          end
          default: begin
            if (w_pad_last) begin
              r_state <= ST_HEAD;
            end
          end
        endcase
      end
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt - 2'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  // Entry 0 is the presented word; it only changes when popped or when the buffer is empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= 2'd0;
      r_b0  <= '0;
      r_b1  <= '0;
      r_rdy <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_rdy <= (w_cnt_nxt != 2'd2);
      if (w_pop) begin
        if (r_cnt == 2'd2) begin
          r_b0 <= r_b1;
        end else if (w_push) begin
          r_b0 <= w_entry;
        end
      end else if (w_push) begin
        if (r_cnt == 2'd0) begin
          r_b0 <= w_entry;
        end else begin
          r_b1 <= w_entry;
        end
      end
    end
  end

  assign bus.i_rdy = r_rdy;
  assign bus.o_val = (r_cnt != 2'd0);
  assign bus.o_dat = r_b0[c_ew-1 -: WIDTH];
  assign bus.o_chn = r_b0[c_ch_width+1:2];
  assign bus.o_sop = r_b0[1];
  assign bus.o_eop = r_b0[0];
  assign bus.o_err = r_err;

endmodule

`default_nettype wire

// File: doc/ps_defragmenter_unpacker_mc.md
PS_DEFRAGMENTER_UNPACKER_MC -- requirements
Module: ps_defragmenter_unpacker_mc

Interface
REQ-001 Parameter WIDTH, 16: stream word width.
REQ-002 Parameter ALIGN, 2: fragment alignment step in words, header included; values of 1 or more allowed; 1 means no padding.
REQ-003 Parameter LEN_WIDTH, 8: width of the header length field, which encodes payload length minus 1.
REQ-004 Parameter CHANNELS, 4: number of logical channels; values of 1 or more allowed; CH_WIDTH = CHANNELS > 1 ? clog2(CHANNELS) : 1.
REQ-005 Constraint: 1 + CH_WIDTH + LEN_WIDTH <= WIDTH; elaboration fails otherwise.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 clk  input  1  single clock; all logic on its rising edge.
REQ-008 i_dat  input  WIDTH  input DataStream word.
REQ-009 i_val  input  1  input word valid.
REQ-010 i_rdy  output  1  input ready; registered, with no combinational path from o_rdy.
REQ-011 o_dat  output  WIDTH  output payload word.
REQ-012 o_chn  output  CH_WIDTH  channel of the output word.
REQ-013 o_val  output  1  output valid.
REQ-014 o_sop  output  1  first word of a packet on o_chn.
REQ-015 o_eop  output  1  last word of a packet on o_chn.
REQ-016 o_rdy  input  1  output ready.
REQ-017 o_err  output  1  one-cycle pulse marking a bad-channel fragment.

Function
REQ-018 Header word fields: bit WIDTH-1 = fin; bits [LEN_WIDTH+CH_WIDTH-1 : LEN_WIDTH] = chn, forced to 0 when CHANNELS = 1; bits [LEN_WIDTH-1 : 0] = len-1.
- Header bits not covered by these fields are ignored.
REQ-019 A fragment is laid out as header, then len payload words (1 to 2^LEN_WIDTH), then pad words.
- pad = (ALIGN - ((len+1) mod ALIGN)) mod ALIGN.
REQ-020 Input transfer: i_val & i_rdy. Output transfer: o_val & o_rdy.
REQ-021 The FSM has four states:
- st_head: consume one header word.
- st_pass: forward payload words.
- st_drop: discard payload words of a bad fragment.
- st_align: discard pad words.
REQ-022 Transitions out of st_head, taken on a header transfer:
- chn < CHANNELS: go to st_pass.
- chn >= CHANNELS: go to st_drop, and assert o_err for exactly one cycle.
REQ-023 Transitions out of st_pass and st_drop, taken on the transfer of payload word len:
- pad > 0: go to st_align.
- pad = 0: go to st_head.
REQ-024 Transition out of st_align, taken on the transfer of the last pad word: go to st_head.
REQ-025 Header and pad words are never presented on the output.
- Words discarded in st_drop are never presented on the output.
REQ-026 Each forwarded payload word carries:
- o_chn = chn of its fragment.
- o_eop = 1 only on payload word len of a fragment with fin = 1.
REQ-027 Per-channel register sop_pend[CHANNELS]:
- Reset value: all ones.
- o_sop = sop_pend[chn] on each forwarded word.
- Cleared on a forwarded word; set again when that word has o_eop = 1.
- Fragments of different channels may interleave; each channel keeps independent sop/eop tracking.
REQ-028 A single-word packet (fin = 1, len = 1) with sop_pend set produces o_sop = o_eop = 1 on the same word.
REQ-029 The output stage is a 2-entry skid buffer:
- Latency from input transfer to o_val is 1 cycle.
- Sustained throughput is 1 word/cycle while o_rdy = 1.
- i_rdy = 0 only while the buffer is full.
- o_dat, o_chn, o_sop and o_eop are held stable while o_val & ~o_rdy.
REQ-030 Header, pad and drop words are accepted at 1 word/cycle whenever the buffer is not full.
REQ-031 Counters:
- Length counter is LEN_WIDTH bits and counts down from len-1 to 0; it never wraps.
- Align counter is clog2(ALIGN) bits, present only for ALIGN > 1.
REQ-032 i_val low in any state holds all state; there is no timeout.

Reset
REQ-033 Reset, sampled synchronously and active-high, puts the block into its idle state:
- FSM in st_head.
- Skid buffer emptied.
- sop_pend all ones.
- Counters cleared.
REQ-034 Output values during reset and in the cycle after it:
- o_val = 0, o_err = 0, o_sop = 0, o_eop = 0, o_dat = 0, o_chn = 0.
- i_rdy = 0 during reset; i_rdy = 1 in the first cycle after reset.
REQ-035 Reset asserted mid-fragment discards any partial fragment; the next input word after reset is treated as a header.

Verification
REQ-036 WIDTH=16, ALIGN=4, CHANNELS=4, LEN_WIDTH=8, o_rdy=1; input 0x8102, A, B, C -> output A,B,C on chn 1, zero pad words consumed.
- A: sop=1. C: eop=1. One word per cycle, first output 1 cycle after A is accepted.
REQ-037 Header 0x0001 (chn 0, len 2, fin 0) + 2 words + 1 pad word, then header 0x8000 + 1 word + 2 pad words -> output 3 words on chn 0.
- sop on word 1, eop on word 3.
- Pad words absent from the output.
REQ-038 Interleaving: chn 2 fragment (fin 0, len 1), chn 3 fragment (fin 1, len 1), chn 2 fragment (fin 1, len 1).
- chn 3 word: sop=1, eop=1.
- Second chn 2 word: sop=0, eop=1.
REQ-039 CHANNELS=3, header 0x0301 (chn 3, len 2) + 2 payload words + 1 pad word -> o_err high for exactly 1 cycle, no output words; the next header is decoded normally.
REQ-040 Random o_rdy toggling (50%) over 1000 fragments checks:
- No output word lost or duplicated.
- Output held stable while stalled.
- i_rdy never depends combinationally on o_rdy.
REQ-041 Reset asserted on the 2nd payload word of a len-5 fragment -> o_val = 0 on the next cycle; the following word 0x8000 is decoded as a header.
